// File: rtl/edge_pulse_gen.sv
// Hysteresis and debounce edge detector for a sampled analog code.
// Emits registered rise/fall pulses and a debounced level, and keeps saturating edge counters.
module edge_pulse_gen #(
  parameter int unsigned W     = 8,
  parameter int unsigned TH_HI = 180,
  parameter int unsigned TH_LO = 75,
  parameter int unsigned DEB   = 3,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  sample,
  input  logic          sample_valid,
  input  logic          clear_cnt,
  output logic          rising_edge,
  output logic          falling_edge,
  output logic          level,
  output logic [CW-1:0] rise_cnt,
  output logic [CW-1:0] fall_cnt,
  output logic          sat
);

  generate
    if ((TH_LO >= TH_HI) || (DEB < 1)) begin : g_param_check
      $error("edge_pulse_gen: requires TH_LO < TH_HI and DEB >= 1");
    end
  endgenerate

  localparam int unsigned    DW       = (DEB > 1) ? $clog2(DEB + 1) : 1;
  localparam logic [W-1:0]   HI_CODE  = W'(TH_HI);
  localparam logic [W-1:0]   LO_CODE  = W'(TH_LO);
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEB - 1);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_dcnt;
  logic            r_rise;
  logic            r_fall;
  logic            r_level;
  logic [CW-1:0]   r_rise_cnt;
  logic [CW-1:0]   r_fall_cnt;
  logic            r_sat;

  state_t          w_state_nxt;
  logic [DW-1:0]   w_dcnt_nxt;
  logic            w_rise;
  logic            w_fall;
  logic            w_hi;
  logic            w_lo;
  logic            w_level_nxt;

  assign w_hi        = (sample >= HI_CODE);
  assign w_lo        = (sample <= LO_CODE);
  assign w_level_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALL_PEND);

  // Next-state and edge-confirm decode; only a valid sample can move the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    if (sample_valid) begin
      case (r_state)
        ST_LOW: begin
          if (w_hi) begin
            if (DEB == 1) begin
              w_state_nxt = ST_HIGH;
              w_dcnt_nxt  = '0;
              w_rise      = 1'b1;
            end else begin
              w_state_nxt = ST_RISE_PEND;
              w_dcnt_nxt  = DW'(1);
            end
          end else begin
            w_state_nxt = ST_LOW;
            w_dcnt_nxt  = '0;
          end
        end
        ST_RISE_PEND: begin
          if (w_hi) begin
            if (r_dcnt == DEB_LAST) begin
              w_state_nxt = ST_HIGH;
              w_dcnt_nxt  = '0;
              w_rise      = 1'b1;
            end else begin
              w_dcnt_nxt  = r_dcnt + DW'(1);
            end
          end else begin
            w_state_nxt = ST_LOW;
            w_dcnt_nxt  = '0;
          end
        end
        ST_HIGH: begin
          if (w_lo) begin
            if (DEB == 1) begin
              w_state_nxt = ST_LOW;
              w_dcnt_nxt  = '0;
              w_fall      = 1'b1;
            end else begin
              w_state_nxt = ST_FALL_PEND;
              w_dcnt_nxt  = DW'(1);
            end
          end else begin
            w_state_nxt = ST_HIGH;
            w_dcnt_nxt  = '0;
          end
        end
        ST_FALL_PEND: begin
          if (w_lo) begin
            if (r_dcnt == DEB_LAST) begin
              w_state_nxt = ST_LOW;
              w_dcnt_nxt  = '0;
              w_fall      = 1'b1;
            end else begin
              w_dcnt_nxt  = r_dcnt + DW'(1);
            end
          end else begin
            w_state_nxt = ST_HIGH;
            w_dcnt_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_LOW;
          w_dcnt_nxt  = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
    end
  end

  // State, pulses, level and counters; clear beats a same-cycle increment but not the pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_LOW;
      r_dcnt     <= '0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_level    <= 1'b0;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_level <= w_level_nxt;
      if (clear_cnt) begin
        r_rise_cnt <= '0;
        r_fall_cnt <= '0;
        r_sat      <= 1'b0;
      end else begin
        if (w_rise) begin
          if (r_rise_cnt == CNT_MAX) begin
            r_sat <= 1'b1;
          end else begin
            r_rise_cnt <= r_rise_cnt + CW'(1);
          end
        end else begin
          r_rise_cnt <= r_rise_cnt;
        end
        if (w_fall) begin
          if (r_fall_cnt == CNT_MAX) begin
            r_sat <= 1'b1;
          end else begin
            r_fall_cnt <= r_fall_cnt + CW'(1);
          end
        end else begin
          r_fall_cnt <= r_fall_cnt;
        end
      end
    end
  end

  assign rising_edge  = r_rise;
  assign falling_edge = r_fall;
  assign level        = r_level;
  assign rise_cnt     = r_rise_cnt;
  assign fall_cnt     = r_fall_cnt;
  assign sat          = r_sat;

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Producer side of the edge-pulse interface consumed by the verification scoreboard.
- Takes a sampled unsigned analog code (ADC/comparator front-end output) and applies hysteresis thresholds plus a consecutive-sample debounce.
- Emits one-cycle rising_edge / falling_edge pulses and a level output.
- Keeps saturating edge counters that the scoreboard totals are checked against.

Parameters:
W, 8, sample code width in bits
TH_HI, 180, rise threshold: a valid sample >= TH_HI qualifies as high
TH_LO, 75, fall threshold: a valid sample <= TH_LO qualifies as low
DEB, 3, consecutive qualifying valid samples required to confirm an edge (>=1)
CW, 16, edge counter width

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset)
sample  input  W  unsigned sample code
sample_valid  input  1  sample is consumed on this clock edge only when 1
clear_cnt  input  1  synchronous clear of counters and the sat flag
rising_edge  output  1  one-cycle pulse on a confirmed low->high transition
falling_edge  output  1  one-cycle pulse on a confirmed high->low transition
level  output  1  debounced level (1 in HIGH/FALL_PEND)
rise_cnt  output  CW  confirmed rising edges, saturating
fall_cnt  output  CW  confirmed falling edges, saturating
sat  output  1  sticky; set when either counter is at all-ones and another edge confirms

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low: when reset=0 at a posedge, the block resets.
- Reset values: state=LOW, debounce counter=0, level=0, rising_edge=0, falling_edge=0, rise_cnt=0, fall_cnt=0, sat=0. Reset overrides every other input. Reset mid-debounce discards the pending edge and emits no pulse.
- Elaboration checks: TH_LO < TH_HI and DEB >= 1, otherwise elaboration error.
- States: LOW, RISE_PEND, HIGH, FALL_PEND. The debounce counter dcnt is wide enough for DEB.
- State and counters change only on posedges with sample_valid=1. On sample_valid=0 cycles, state, dcnt and level hold and both pulses are 0.
- LOW:
  - sample>=TH_HI: if DEB==1, go to HIGH and confirm a rise; else go to RISE_PEND with dcnt=1.
  - Otherwise stay in LOW.
- RISE_PEND:
  - sample>=TH_HI: dcnt+1. When dcnt+1==DEB, go to HIGH, confirm a rise, dcnt=0.
  - sample<TH_HI, including the hysteresis band: go to LOW, dcnt=0, no pulse.
- HIGH: mirror of LOW using sample<=TH_LO, leading to FALL_PEND or, if DEB==1, a direct fall.
- FALL_PEND:
  - sample<=TH_LO: dcnt+1; the DEB-th qualifying sample goes to LOW and confirms a fall.
  - sample>TH_LO: go to HIGH, dcnt=0.
- Hysteresis band: samples strictly between TH_LO and TH_HI never change a confirmed level. They do abort a pending edge.
- Confirmed edge (registered):
  - The pulse is high for exactly the one cycle following the posedge that consumed the DEB-th sample.
  - level updates on that same edge.
  - The counter increments on that same edge.
  - Total latency from the first qualifying sample edge: DEB clock edges when samples are back-to-back; invalid cycles stretch it.
- rising_edge and falling_edge are never high together. Consecutive pulses of the same kind are impossible; edges alternate strictly.
- Counters saturate at 2^CW-1. A confirmed edge at saturation leaves the counter unchanged and sets sat.
- clear_cnt=1 sets both counters and sat to 0. Clear takes priority over a simultaneous increment. The pulse, state and level are unaffected, so an edge confirming in the clear cycle is not counted.
- Outputs are plain 1-bit digital. Connect modules map them onto the scoreboard's real-valued inputs, so 1 maps to 1.0.

Test Plan:
- Reset held (reset=0) 5 cycles with sample=255 valid -> all outputs 0, state LOW. Release, then 3 valid samples of 200 -> rising_edge high for the 1 cycle after the 3rd sample edge, level=1, rise_cnt=1.
- From HIGH: samples 70,70,100,70,70,70 -> the abort at 100 gives no pulse; falling_edge fires after the 6th sample, fall_cnt=1, level=0.
- Hysteresis: from LOW, 500 valid samples alternating 120/170 -> no pulses, level stays 0, counters stay 0.
- Gapped valid: 200,(valid=0 x4),200,(valid=0),200 -> single rising_edge after the 3rd valid sample, no effect from invalid cycles.
- Saturation with CW=2: 4 full rise/fall cycles -> rise_cnt=3 and fall_cnt=3 after the 3rd cycle. The 4th rise sets sat=1 and rise_cnt stays 3. clear_cnt then gives 0,0,0.
- Clear collision: clear_cnt=1 on the confirming edge -> rising_edge still pulses, rise_cnt=0. Reset asserted while in RISE_PEND with dcnt=2 -> no pulse, state LOW.
